// File: rtl/tqvp_ofdm_pkg.sv
// Shared encodings for the OFDM constellation mapper: modes, FSM states,
// register addresses, bits-per-symbol lookup and Gray-coded level helpers.
package tqvp_ofdm_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_QAM16 = 2'b10,
    MODE_QAM64 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STARVE = 2'd2,
    ST_STALL  = 2'd3
  } state_e;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_SYM_I  = 4'h3;
  localparam logic [3:0] ADDR_LEVEL  = 4'h4;
  localparam logic [3:0] ADDR_BITCNT = 4'h5;
  localparam logic [3:0] ADDR_SYM_Q  = 4'h6;
  localparam logic [3:0] ADDR_SYM_PK = 4'h7;

  // Only enable, mode and stream-enable are stored; flush is a pulse.
  localparam logic [7:0] CTRL_RW_MASK = 8'h17;

  function automatic logic [2:0] bps_of(mode_e m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd6;
    endcase
  endfunction

  function automatic logic signed [3:0] lvl_pm1(logic b);
    return b ? -4'sd1 : 4'sd1;
  endfunction

  function automatic logic signed [3:0] lvl_qam16(logic [1:0] b);
    case (b)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      default: return 4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] lvl_qam64(logic [2:0] b);
    case (b)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      default: return 4'sd7;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_ofdm_sym_fifo.sv
// Symbol FIFO: power-of-two depth, flush overrides push/pop; push when full
// and pop when empty are ignored.
module tqvp_ofdm_sym_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/tqvp_ofdm_mapper.sv
// OFDM constellation mapper peripheral: bytes written to DATA are sliced LSB
// first into BPSK/QPSK/16QAM/64QAM symbols and queued for register readout.
module tqvp_ofdm_mapper
  import tqvp_ofdm_pkg::*;
#(
  parameter int COMP_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = 2 * COMP_W;

  logic [7:0]  r_ctrl;
  logic        r_ovf, r_udf;
  logic [15:0] r_bitbuf;
  logic [4:0]  r_bitcnt;
  state_e      r_state, w_state_next;

  // Bus: data_write is a one-cycle strobe qualifying address/data_in; every
  // strobe is accepted, reads are purely combinational on address.
  logic w_wr_ctrl, w_wr_status, w_wr_data, w_wr_pop;
  logic w_flush, w_push, w_pop, w_data_acc, w_en_next;
  mode_e w_mode, w_mode_next;
  logic [4:0] w_bps, w_bps_next, w_consume, w_rem, w_bitcnt_next;
  logic [15:0] w_buf_next;
  logic signed [3:0] w_lvl_i, w_lvl_q;
  logic [SW-1:0] w_sym, w_head;
  logic signed [COMP_W-1:0] w_head_i, w_head_q;
  logic [CW-1:0] w_count, w_count_next;
  logic w_full, w_empty, w_full_next;
  logic [7:0] w_sym_pk;
  logic w_unused_ok;

  assign w_unused_ok = ^ui_in;

  assign w_wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign w_wr_status = data_write && (address == ADDR_STATUS);
  assign w_wr_data   = data_write && (address == ADDR_DATA);
  assign w_wr_pop    = data_write && (address == ADDR_SYM_I);
  assign w_flush     = w_wr_ctrl && data_in[3];
  assign w_mode      = mode_e'(r_ctrl[2:1]);
  assign w_bps       = {2'b00, bps_of(w_mode)};
  assign w_push      = (r_state == ST_RUN) && !w_flush;
  assign w_pop       = w_wr_pop && !w_empty && !w_flush;
  assign w_data_acc  = w_wr_data && (r_bitcnt <= 5'd8) && !w_flush;

  always_comb begin
    w_lvl_i = 4'sd0;
    w_lvl_q = 4'sd0;
    case (w_mode)
      MODE_BPSK:  w_lvl_i = lvl_pm1(r_bitbuf[0]);
      MODE_QPSK: begin
        w_lvl_i = lvl_pm1(r_bitbuf[0]);
        w_lvl_q = lvl_pm1(r_bitbuf[1]);
      end
      MODE_QAM16: begin
        w_lvl_i = lvl_qam16(r_bitbuf[1:0]);
        w_lvl_q = lvl_qam16(r_bitbuf[3:2]);
      end
      default: begin
        w_lvl_i = lvl_qam64(r_bitbuf[2:0]);
        w_lvl_q = lvl_qam64(r_bitbuf[5:3]);
      end
    endcase
  end

  assign w_sym = {COMP_W'(w_lvl_q), COMP_W'(w_lvl_i)};

  // Consume first, then append the new byte directly above what remains.
  always_comb begin
    w_consume     = w_push ? w_bps : 5'd0;
    w_rem         = r_bitcnt - w_consume;
    w_buf_next    = r_bitbuf >> w_consume;
    w_bitcnt_next = w_rem;
    if (w_data_acc) begin
      w_buf_next    = w_buf_next | ({8'h00, data_in} << w_rem);
      w_bitcnt_next = w_rem + 5'd8;
    end
    if (w_flush) begin
      w_buf_next    = '0;
      w_bitcnt_next = '0;
    end
  end

  assign w_count_next = w_flush ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  assign w_full_next  = (w_count_next == CW'(FIFO_DEPTH));

  // State is registered from next-cycle inputs so RUN in a cycle means a push.
  always_comb begin
    w_en_next   = r_ctrl[0];
    w_mode_next = w_mode;
    if (w_wr_ctrl) begin
      w_en_next   = data_in[0];
      w_mode_next = mode_e'(data_in[2:1]);
    end
    w_bps_next   = {2'b00, bps_of(w_mode_next)};
    w_state_next = ST_RUN;
    if (!w_en_next)                       w_state_next = ST_IDLE;
    else if (w_bitcnt_next < w_bps_next)  w_state_next = ST_STARVE;
    else if (w_full_next)                 w_state_next = ST_STALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_bitbuf <= '0;
      r_bitcnt <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= data_in & CTRL_RW_MASK;
      r_bitbuf <= w_buf_next;
      r_bitcnt <= w_bitcnt_next;
      if (w_flush) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        r_ovf <= (r_ovf && !(w_wr_status && data_in[2])) || (w_wr_data && !w_data_acc);
        r_udf <= (r_udf && !(w_wr_status && data_in[3])) || (w_wr_pop && w_empty);
      end
    end
  end

  tqvp_ofdm_sym_fifo #(.W(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_sym),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_i = w_head[COMP_W-1:0];
  assign w_head_q = w_head[SW-1:COMP_W];
  assign w_sym_pk = w_empty ? 8'h00 : {w_head_q[3:0], w_head_i[3:0]};
  assign uo_out   = r_ctrl[4] ? w_sym_pk : 8'h00;

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:   data_out = r_ctrl;
      ADDR_STATUS: data_out = {2'b00, r_state, r_udf, r_ovf, w_full, w_empty};
      ADDR_SYM_I:  data_out = w_empty ? 8'h00 : 8'(w_head_i);
      ADDR_LEVEL:  data_out = 8'(w_count);
      ADDR_BITCNT: data_out = {3'b000, r_bitcnt};
      ADDR_SYM_Q:  data_out = w_empty ? 8'h00 : 8'(w_head_q);
      ADDR_SYM_PK: data_out = w_sym_pk;
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_ofdm_mapper.sv
// Directed bench for tqvp_ofdm_mapper: register-level stimulus with
// hand-computed constellation points.
module tb_tqvp_ofdm_mapper;
  import tqvp_ofdm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  tqvp_ofdm_mapper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    address = a;
    #1;
    v = data_out;
    check(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check_reg(tag, ADDR_SYM_PK, exp_q.pop_front());
      bus_write(ADDR_SYM_I, 8'h00);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; address = '0; data_in = '0; data_write = 1'b0; ui_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reg("rst_ctrl", ADDR_CTRL, 8'h00);
    check_reg("rst_status", ADDR_STATUS, 8'h01);
    check("rst_uo_out", uo_out, 8'h00);
    rst_n = 1'b1;
    idle(1);
    check_reg("rst_level", ADDR_LEVEL, 8'h00);
    check_reg("rst_bitcnt", ADDR_BITCNT, 8'h00);
    check_reg("unmapped_rd", 4'h9, 8'h00);

    // QPSK with stream output, including first-symbol latency
    ui_in = 8'hA5;
    bus_write(ADDR_CTRL, 8'h13);
    bus_write(ADDR_DATA, 8'hE4);
    check_reg("qpsk_lat_n1", ADDR_LEVEL, 8'h00);
    check_reg("data_rd_zero", ADDR_DATA, 8'h00);
    idle(1);
    check_reg("qpsk_lat_n2", ADDR_LEVEL, 8'h01);
    idle(4);
    check_reg("qpsk_level", ADDR_LEVEL, 8'h04);
    check("qpsk_uo_out", uo_out, 8'h11);
    exp_q = '{8'h11, 8'h1F, 8'hF1, 8'hFF};
    drain("qpsk_pk");
    check_reg("qpsk_status", ADDR_STATUS, 8'h21);
    check_reg("qpsk_bitcnt", ADDR_BITCNT, 8'h00);
    check("qpsk_uo_empty", uo_out, 8'h00);

    // 16QAM, stream disabled
    bus_write(ADDR_CTRL, 8'h05);
    bus_write(ADDR_DATA, 8'hB4);
    idle(3);
    check_reg("q16_level", ADDR_LEVEL, 8'h02);
    check_reg("q16_sym_i0", ADDR_SYM_I, 8'hFD);
    check_reg("q16_sym_q0", ADDR_SYM_Q, 8'hFF);
    check("q16_uo_off", uo_out, 8'h00);
    check_reg("q16_pk0", ADDR_SYM_PK, 8'hFD);
    bus_write(ADDR_SYM_I, 8'h00);
    check_reg("q16_pk1", ADDR_SYM_PK, 8'h31);
    check_reg("q16_sym_i1", ADDR_SYM_I, 8'h01);
    check_reg("q16_sym_q1", ADDR_SYM_Q, 8'h03);
    bus_write(ADDR_SYM_I, 8'h00);

    // 64QAM, second byte written in the same cycle as a consume
    bus_write(ADDR_CTRL, 8'h07);
    bus_write(ADDR_DATA, 8'hFF);
    bus_write(ADDR_DATA, 8'h00);
    idle(3);
    check_reg("q64_level", ADDR_LEVEL, 8'h02);
    exp_q = '{8'h33, 8'h9D};
    drain("q64_pk");
    check_reg("q64_bitcnt", ADDR_BITCNT, 8'h04);
    check_reg("q64_status", ADDR_STATUS, 8'h21);

    bus_write(ADDR_CTRL, 8'h08);
    check_reg("flush_ctrl", ADDR_CTRL, 8'h00);
    check_reg("flush_bitcnt", ADDR_BITCNT, 8'h00);
    check_reg("flush_status", ADDR_STATUS, 8'h01);

    // Overflow / underflow sticky flags while disabled
    bus_write(ADDR_DATA, 8'hA5);
    bus_write(ADDR_DATA, 8'h5A);
    bus_write(ADDR_DATA, 8'hFF);
    check_reg("ovf_bitcnt", ADDR_BITCNT, 8'h10);
    check_reg("ovf_status", ADDR_STATUS, 8'h05);
    check_reg("ovf_level", ADDR_LEVEL, 8'h00);
    bus_write(ADDR_STATUS, 8'h04);
    check_reg("ovf_clear", ADDR_STATUS, 8'h01);
    bus_write(ADDR_SYM_I, 8'h00);
    check_reg("udf_set", ADDR_STATUS, 8'h09);
    bus_write(ADDR_STATUS, 8'h08);
    check_reg("udf_clear", ADDR_STATUS, 8'h01);

    // Frozen while disabled, then mode change between consecutive pushes
    bus_write(ADDR_CTRL, 8'h08);
    bus_write(ADDR_DATA, 8'hE4);
    idle(2);
    check_reg("frz_bitcnt", ADDR_BITCNT, 8'h08);
    check_reg("frz_level", ADDR_LEVEL, 8'h00);
    bus_write(ADDR_CTRL, 8'h05);
    bus_write(ADDR_CTRL, 8'h03);
    idle(3);
    check_reg("mchg_level", ADDR_LEVEL, 8'h03);
    exp_q = '{8'hFD, 8'hF1, 8'hFF};
    drain("mchg_pk");
    check_reg("mchg_bitcnt", ADDR_BITCNT, 8'h00);

    // BPSK fill to full, then pop releases exactly one push
    bus_write(ADDR_CTRL, 8'h01);
    bus_write(ADDR_DATA, 8'h00);
    bus_write(ADDR_DATA, 8'h00);
    idle(12);
    check_reg("bpsk_level", ADDR_LEVEL, 8'h08);
    check_reg("bpsk_status", ADDR_STATUS, 8'h32);
    check_reg("bpsk_bitcnt", ADDR_BITCNT, 8'h08);
    check_reg("bpsk_pk", ADDR_SYM_PK, 8'h01);
    bus_write(ADDR_SYM_I, 8'h00);
    check_reg("bpsk_pop_level", ADDR_LEVEL, 8'h07);
    check_reg("bpsk_pop_status", ADDR_STATUS, 8'h10);
    idle(1);
    check_reg("bpsk_refill_level", ADDR_LEVEL, 8'h08);
    check_reg("bpsk_refill_bitcnt", ADDR_BITCNT, 8'h07);
    check_reg("bpsk_refill_status", ADDR_STATUS, 8'h32);

    // Asynchronous reset mid-run
    bus_write(ADDR_CTRL, 8'h08);
    bus_write(ADDR_CTRL, 8'h13);
    bus_write(ADDR_DATA, 8'hFF);
    bus_write(ADDR_DATA, 8'hFF);
    idle(4);
    check_reg("run_level", ADDR_LEVEL, 8'h05);
    check_reg("run_status", ADDR_STATUS, 8'h10);
    check("run_uo_out", uo_out, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("arst_uo_out", uo_out, 8'h00);
    check_reg("arst_ctrl", ADDR_CTRL, 8'h00);
    check_reg("arst_status", ADDR_STATUS, 8'h01);
    check_reg("arst_level", ADDR_LEVEL, 8'h00);
    check_reg("arst_bitcnt", ADDR_BITCNT, 8'h00);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    bus_write(ADDR_SYM_I, 8'h00);
    check_reg("arst_udf", ADDR_STATUS, 8'h09);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
